// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encodings and helpers shared by the universal shift register
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    function automatic logic is_shift(input logic [1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR);
    endfunction

endpackage

// File: rtl/dff_bit.sv
// rtl/dff_bit.sv - one register bit: 4:1 mode mux feeding a flop with async reset value
module dff_bit
    import shift_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rst_val,
    input  logic [1:0] sel,
    input  logic       shl_in,
    input  logic       shr_in,
    input  logic       load_in,
    output logic       q
);

    logic nxt;

    always_comb begin
        nxt = q;
        case (sel)
            MODE_SHL:  nxt = shl_in;
            MODE_SHR:  nxt = shr_in;
            MODE_LOAD: nxt = load_in;
            default:   nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with serial out, shift counter and done pulse
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             d,
    input  logic                         sin_r,
    input  logic                         sin_l,
    output logic [WIDTH-1:0]             q,
    output logic [WIDTH-1:0]             qb,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         done
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0] sel;
    logic       shift_en;
    logic       load_en;

    // Disabled cycles look like HOLD to every bit, so the bits never see en.
    assign sel      = en ? mode : 2'(MODE_HOLD);
    assign shift_en = is_shift(sel);
    assign load_en  = (sel == 2'(MODE_LOAD));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shl_in;
        logic shr_in;

        if (i == 0) begin : g_lsb
            assign shl_in = sin_r;
        end else begin : g_shl
            assign shl_in = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign shr_in = sin_l;
        end else begin : g_shr
            assign shr_in = q[i+1];
        end

        dff_bit u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RESET_VAL[i]),
            .sel     (sel),
            .shl_in  (shl_in),
            .shr_in  (shr_in),
            .load_in (d[i]),
            .q       (q[i])
        );
    end

    assign qb = ~q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout <= 1'b0;
        end else if (sel == 2'(MODE_SHL)) begin
            sout <= q[WIDTH-1];
        end else if (sel == 2'(MODE_SHR)) begin
            sout <= q[0];
        end else if (load_en) begin
            sout <= 1'b0;
        end
    end

    // done fires only on the shift that reaches WIDTH, never on saturated shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= shift_en && (cnt == CNT_LAST);
            if (load_en) begin
                cnt <= '0;
            end else if (shift_en && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg at WIDTH=8
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] d;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         sout;
    logic [3:0]   cnt;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .q     (q),
        .qb    (qb),
        .sout  (sout),
        .cnt   (cnt),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on integers.
    int m_q;
    int m_sout;
    int m_cnt;
    int m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= 0;
            m_sout <= 0;
            m_cnt  <= 0;
            m_done <= 0;
        end else begin
            m_done <= 0;
            if (en) begin
                if (mode == 2'd1) begin
                    m_q    <= (m_q * 2 + int'(sin_r)) % 256;
                    m_sout <= m_q / 128;
                end else if (mode == 2'd2) begin
                    m_q    <= m_q / 2 + 128 * int'(sin_l);
                    m_sout <= m_q % 2;
                end else if (mode == 2'd3) begin
                    m_q    <= int'(d);
                    m_sout <= 0;
                    m_cnt  <= 0;
                end
                if (mode == 2'd1 || mode == 2'd2) begin
                    m_cnt  <= (m_cnt + 1 > W) ? W : m_cnt + 1;
                    m_done <= (m_cnt + 1 == W) ? 1 : 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_q",    64'(q),    64'(m_q));
        check("model_qb",   64'(qb),   64'(255 - m_q));
        check("model_sout", 64'(sout), 64'(m_sout));
        check("model_cnt",  64'(cnt),  64'(m_cnt));
        check("model_done", 64'(done), 64'(m_done));
    end

    task automatic cyc(input logic e, input logic [1:0] m, input logic [W-1:0] dv,
                       input logic sr, input logic sl);
        en    = e;
        mode  = m;
        d     = dv;
        sin_r = sr;
        sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_sout;
    int         done_seen;

    initial begin
        exp_sout = 8'b1010_0101;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        d     = '0;
        sin_r = 1'b0;
        sin_l = 1'b0;
        #2;
        check("rst_q",    64'(q),    64'h00);
        check("rst_qb",   64'(qb),   64'hFF);
        check("rst_cnt",  64'(cnt),  64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sout", 64'(sout), 64'd0);
        #10;
        rst_n = 1'b1;

        cyc(1, 2'd3, 8'hA5, 0, 0);
        check("load_q",    64'(q),    64'hA5);
        check("load_qb",   64'(qb),   64'h5A);
        check("load_cnt",  64'(cnt),  64'd0);
        check("load_sout", 64'(sout), 64'd0);

        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 2'd1, 8'h00, 0, 0);
            check("shl_sout", 64'(sout), 64'(exp_sout[7-i]));
            check("shl_cnt",  64'(cnt),  64'(i + 1));
            check("shl_done", 64'(done), 64'(i == 7));
            if (done) done_seen++;
        end
        check("shl_q_end", 64'(q), 64'h00);
        cyc(1, 2'd1, 8'h00, 0, 0);
        if (done) done_seen++;
        check("shl9_cnt",   64'(cnt),  64'd8);
        check("shl9_done",  64'(done), 64'd0);
        check("done_count", 64'(done_seen), 64'd1);

        cyc(1, 2'd3, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 2'd2, 8'h00, 0, 1);
        check("shr_q",    64'(q),    64'hF0);
        check("shr_cnt",  64'(cnt),  64'd4);
        check("shr_done", 64'(done), 64'd0);

        for (int i = 0; i < 3; i++) cyc(0, 2'd3, 8'hFF, 1, 1);
        check("dis_q",    64'(q),    64'hF0);
        check("dis_cnt",  64'(cnt),  64'd4);
        check("dis_sout", 64'(sout), 64'd0);
        cyc(1, 2'd0, 8'hFF, 1, 1);
        check("hold_q",   64'(q),    64'hF0);
        check("hold_cnt", 64'(cnt),  64'd4);

        cyc(1, 2'd3, 8'h81, 0, 0);
        cyc(1, 2'd1, 8'h00, 0, 0);
        cyc(1, 2'd2, 8'h00, 0, 0);
        cyc(1, 2'd1, 8'h00, 1, 0);
        check("mix_cnt", 64'(cnt), 64'd3);
        check("mix_q",   64'(q),   64'h03);

        cyc(1, 2'd3, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 2'd1, 8'h00, 1, 0);
        check("pre_rst_q", 64'(q), 64'hE7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_q",   64'(q),   64'h00);
        check("mid_rst_qb",  64'(qb),  64'hFF);
        check("mid_rst_cnt", 64'(cnt), 64'd0);
        #2;
        rst_n = 1'b1;
        cyc(1, 2'd1, 8'h00, 1, 0);
        check("post_rst_q",   64'(q),   64'h01);
        check("post_rst_cnt", 64'(cnt), 64'd1);

        cyc(1, 2'd3, 8'hFF, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 2'd2, 8'h00, 0, 0);
        check("pend_done", 64'(done), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_kills_done", 64'(done), 64'd0);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
        end

        cyc(0, 2'd0, 8'h00, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
